// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and default-slave state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave giving the two-cycle ERROR response to unmapped accesses
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic       hsel_any,
  input  logic [1:0] htrans,
  output logic       ready,
  output logic       resp
);

  ds_state_t state_q, state_d;
  logic      unmapped;

  // An address phase is accepted only while HREADY is high; active transfers with no select are unmapped
  assign unmapped = hready && !hsel_any &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // State register, cleared asynchronously so outputs return to OKAY/ready at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  // Next state and response: ERR1 stalls with ERROR, ERR2 completes it and accepts the next address
  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (unmapped) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp    = HRESP_ERROR;
        state_d = unmapped ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// rtl/ahb_resp_mux_n.sv - N-slave AHB-Lite response mux with registered data-phase select; AHB_MUX_DEFAULT_ERR_EN enables the ERROR default slave
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
)
(
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HRESP,
  output logic                             HREADY,
  output logic [NUM_SLAVES-1:0]            DPHASE_SEL
);

  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] hsel_low;
  logic                  dflt_ready;
  logic                  dflt_resp;

  // Isolate the lowest set bit so a multi-hot decode still routes to exactly one slave
  assign hsel_low = HSEL & (~HSEL + NUM_SLAVES'(1));

  // Data-phase select advances only when the current transfer completes, keeping wait states on the owner
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= hsel_low;
  end

  assign DPHASE_SEL = sel_q;

`ifdef AHB_MUX_DEFAULT_ERR_EN
  ahb_default_slave u_default_slave (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .hready   (HREADY),
    .hsel_any (|HSEL),
    .htrans   (HTRANS),
    .ready    (dflt_ready),
    .resp     (dflt_resp)
  );
`else
  // Without the default slave, unmapped data phases complete as zero-wait OKAY
  logic unused_htrans;
  assign unused_htrans = ^HTRANS;
  assign dflt_ready    = 1'b1;
  assign dflt_resp     = HRESP_OKAY;
`endif

  // Route the data-phase owner's response; no owner means the default slave answers with zero data
  always_comb begin
    HRDATA = '0;
    HRESP  = dflt_resp;
    HREADY = dflt_ready;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        HRESP  = HRESP_S[i];
        HREADY = HREADYOUT_S[i];
      end
    end
  end

endmodule
